// File: rtl/hedios_event_counters.sv
// -----------------------------------------------------------------------------
// hedios_event_counters
//
// Counts rising edges on COUNTER_COUNT asynchronous event lines into 32-bit
// live counters. An endpoint reads them through a snapshot handshake that
// copies every live counter into the slots registers in a single cycle. A
// separate clear handshake zeroes the live counters and the overflow flags.
//
// Build option:
//   HEDIOS_COUNTER_SATURATE_EN  defined   -> counters stick at 0xFFFFFFFF
//                               undefined -> counters wrap to 0x00000000
//   The overflow flag is set by the saturating or wrapping edge in both builds.
//
// Ports:
//   clk           single clock; all state changes on the rising edge
//   rst           asynchronous, active-low reset
//   event_in      asynchronous event lines; each rising edge is one event
//   snapshot_req  level request, held high until snapshot_ack is seen
//   snapshot_ack  one-cycle acknowledge pulse for the snapshot
//   clear_req     level request to zero the live counters and overflow flags
//   clear_ack     one-cycle acknowledge pulse for the clear
//   slots         captured counter values, COUNTER_COUNT x 32 bits
//   overflow      sticky per-counter overflow flags
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module hedios_event_counters #(
  parameter int COUNTER_COUNT = 4,  // 1..32
  parameter int SYNC_STAGES   = 2   // 2..4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [COUNTER_COUNT-1:0]       event_in,
  input  logic                           snapshot_req,
  output logic                           snapshot_ack,
  input  logic                           clear_req,
  output logic                           clear_ack,
  output logic [COUNTER_COUNT-1:0][31:0] slots,
  output logic [COUNTER_COUNT-1:0]       overflow
);

  typedef enum logic [1:0] {
    SNAP_IDLE     = 2'd0,
    SNAP_CAPTURE  = 2'd1,
    SNAP_ACK      = 2'd2,
    SNAP_WAIT_LOW = 2'd3
  } snap_state_t;

  typedef enum logic [1:0] {
    CLR_IDLE     = 2'd0,
    CLR_ACK      = 2'd1,
    CLR_WAIT_LOW = 2'd2
  } clr_state_t;

  // ---------------------------------------------------------------------------
  // Synchronizers and rising-edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][COUNTER_COUNT-1:0] r_sync;
  logic [COUNTER_COUNT-1:0]                  r_edge_q;
  logic [COUNTER_COUNT-1:0]                  w_edge;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the
  // synchronizer chain into a single stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync   <= '0;
      r_edge_q <= '0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], event_in};
      r_edge_q <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_edge_q;

  // ---------------------------------------------------------------------------
  // Snapshot handshake FSM
  // ---------------------------------------------------------------------------
  snap_state_t r_snap_state;
  snap_state_t w_snap_next;
  logic        w_snap_capture;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_snap_state <= SNAP_IDLE;
    else      r_snap_state <= w_snap_next;
  end

  // NOTE: every output of this block is given a default before the case so
  // no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    w_snap_next    = r_snap_state;
    w_snap_capture = 1'b0;
    snapshot_ack   = 1'b0;
    case (r_snap_state)
      SNAP_IDLE:     if (snapshot_req) w_snap_next = SNAP_CAPTURE;
      SNAP_CAPTURE: begin
        w_snap_capture = 1'b1;
        w_snap_next    = SNAP_ACK;
      end
      SNAP_ACK: begin
        snapshot_ack = 1'b1;
        w_snap_next  = SNAP_WAIT_LOW;
      end
      SNAP_WAIT_LOW: if (!snapshot_req) w_snap_next = SNAP_IDLE;
      default:       w_snap_next = SNAP_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Clear handshake FSM
  // ---------------------------------------------------------------------------
  clr_state_t r_clr_state;
  clr_state_t w_clr_next;
  logic       w_snap_pending;
  logic       w_clr_accept;

  // A clear yields for one cycle to a snapshot that has just been requested,
  // so requests raised together land the clear on the CAPTURE cycle and the
  // snapshot still sees the pre-clear counts.
  assign w_snap_pending = (r_snap_state == SNAP_IDLE) && snapshot_req;
  assign w_clr_accept   = (r_clr_state == CLR_IDLE) && clear_req && !w_snap_pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_clr_state <= CLR_IDLE;
    else      r_clr_state <= w_clr_next;
  end

  always_comb begin
    w_clr_next = r_clr_state;
    clear_ack  = 1'b0;
    case (r_clr_state)
      CLR_IDLE:     if (w_clr_accept) w_clr_next = CLR_ACK;
      CLR_ACK: begin
        clear_ack  = 1'b1;
        w_clr_next = CLR_WAIT_LOW;
      end
      CLR_WAIT_LOW: if (!clear_req) w_clr_next = CLR_IDLE;
      default:      w_clr_next = CLR_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Live counters and overflow flags
  // ---------------------------------------------------------------------------
  logic [COUNTER_COUNT-1:0][31:0] r_cnt;
  logic [COUNTER_COUNT-1:0]       r_ovf;

  // NOTE: the counter and slot arrays are plain flops rather than a RAM, so
  // they take the asynchronous reset like any other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < COUNTER_COUNT; i++) begin
        if (w_clr_accept) begin
          // An edge arriving on the clear cycle is the first event after it.
          r_cnt[i] <= {31'd0, w_edge[i]};
          r_ovf[i] <= 1'b0;
        end else if (w_edge[i]) begin
          if (r_cnt[i] == 32'hFFFF_FFFF) begin
            r_ovf[i] <= 1'b1;
`ifdef HEDIOS_COUNTER_SATURATE_EN
            r_cnt[i] <= 32'hFFFF_FFFF;
`else
            r_cnt[i] <= 32'h0000_0000;
`endif
          end else begin
            r_cnt[i] <= r_cnt[i] + 32'd1;
          end
        end
      end
    end
  end

  assign overflow = r_ovf;

  // ---------------------------------------------------------------------------
  // Snapshot registers: loaded only on CAPTURE from the pre-edge, pre-clear
  // counter values; untouched by clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                slots <= '0;
    else if (w_snap_capture) slots <= r_cnt;
  end

endmodule

// File: tb/tb_hedios_event_counters.sv
`timescale 1ns/1ps

module tb_hedios_event_counters;

  localparam int N = 4;
  localparam int S = 2;

  typedef logic [N-1:0][31:0] slots_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] event_in = '0;
  logic         snapshot_req = 1'b0;
  logic         snapshot_ack;
  logic         clear_req = 1'b0;
  logic         clear_ack;
  slots_t       slots;
  logic [N-1:0] overflow;

  hedios_event_counters #(
    .COUNTER_COUNT(N),
    .SYNC_STAGES  (S)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .event_in    (event_in),
    .snapshot_req(snapshot_req),
    .snapshot_ack(snapshot_ack),
    .clear_req   (clear_req),
    .clear_ack   (clear_ack),
    .slots       (slots),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the live counters and overflow flags.
  slots_t       m_cnt = '0;
  logic [N-1:0] m_ovf = '0;

  // Scoreboard: expected slot contents pushed when a snapshot is requested.
  slots_t sb[$];

  task automatic model_edge(input int i);
    if (m_cnt[i] == 32'hFFFF_FFFF) begin
      m_ovf[i] = 1'b1;
`ifndef HEDIOS_COUNTER_SATURATE_EN
      m_cnt[i] = 32'h0;
`endif
    end else begin
      m_cnt[i] = m_cnt[i] + 32'd1;
    end
  endtask

  // All stimulus tasks start and end just after a falling edge.
  task automatic pulse(input int i, input int hi, input int lo);
    event_in[i] = 1'b1;
    model_edge(i);
    repeat (hi) @(negedge clk);
    event_in[i] = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic snap(output int acks);
    sb.push_back(m_cnt);
    repeat (S + 2) @(negedge clk);
    snapshot_req = 1'b1;
    acks = 0;
    for (int c = 0; c < 20 && acks == 0; c++) begin
      @(negedge clk);
      if (snapshot_ack) acks++;
    end
    repeat (6) begin
      @(negedge clk);
      if (snapshot_ack) acks++;
    end
    snapshot_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic clr(output int acks);
    repeat (S + 2) @(negedge clk);
    clear_req = 1'b1;
    m_cnt = '0;
    m_ovf = '0;
    acks  = 0;
    for (int c = 0; c < 20 && acks == 0; c++) begin
      @(negedge clk);
      if (clear_ack) acks++;
    end
    repeat (4) begin
      @(negedge clk);
      if (clear_ack) acks++;
    end
    clear_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    snapshot_req = 1'b1;
    clear_req    = 1'b1;
    event_in     = '1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (slots !== '0) begin
      n_fail++; $display("FAIL reset_slots: got %h expected 0", slots);
    end
    n_checks++;
    if (overflow !== '0) begin
      n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow);
    end
    n_checks++;
    if (snapshot_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_snapshot_ack: got %b expected 0", snapshot_ack);
    end
    n_checks++;
    if (clear_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_clear_ack: got %b expected 0", clear_ack);
    end
    snapshot_req = 1'b0;
    clear_req    = 1'b0;
    event_in     = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (S + 2) @(negedge clk);
  endtask

  task automatic test_basic();
    int     acks;
    slots_t e;
    for (int p = 0; p < 5; p++) pulse(0, 4, 4);
    sb.push_back(m_cnt);
    repeat (S + 2) @(negedge clk);
    snapshot_req = 1'b1;
    acks = 0;
    for (int c = 0; c < 20 && acks == 0; c++) begin
      @(negedge clk);
      if (snapshot_ack) acks++;
    end
    // Another event while the request is still held must not be captured.
    event_in[0] = 1'b1;
    model_edge(0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 3) event_in[0] = 1'b0;
      if (snapshot_ack) acks++;
    end
    snapshot_req = 1'b0;
    repeat (2) @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (slots !== e) begin
      n_fail++; $display("FAIL basic_slots: got %h expected %h", slots, e);
    end
    n_checks++;
    if (slots[0] !== 32'd5) begin
      n_fail++; $display("FAIL basic_slot0: got %0d expected 5", slots[0]);
    end
    n_checks++;
    if (acks !== 1) begin
      n_fail++; $display("FAIL basic_ack_count: got %0d expected 1", acks);
    end
    snap(acks);
    e = sb.pop_front();
    n_checks++;
    if (slots !== e) begin
      n_fail++; $display("FAIL basic_resnap_slots: got %h expected %h", slots, e);
    end
    n_checks++;
    if (acks !== 1) begin
      n_fail++; $display("FAIL basic_resnap_acks: got %0d expected 1", acks);
    end
  endtask

  task automatic test_overflow();
    int          acks;
    slots_t      e;
    slots_t      pre;
    logic [31:0] exp2;
    clr(acks);
    pre    = '0;
    pre[2] = 32'hFFFF_FFFE;
    force dut.r_cnt = pre;
    #1;
    release dut.r_cnt;
    m_cnt[2] = 32'hFFFF_FFFE;
    for (int p = 0; p < 3; p++) pulse(2, 2, 2);
    snap(acks);
    e = sb.pop_front();
`ifdef HEDIOS_COUNTER_SATURATE_EN
    exp2 = 32'hFFFF_FFFF;
`else
    exp2 = 32'h0000_0001;
`endif
    n_checks++;
    if (slots[2] !== exp2) begin
      n_fail++; $display("FAIL ovf_slot2: got %h expected %h", slots[2], exp2);
    end
    n_checks++;
    if (slots !== e) begin
      n_fail++; $display("FAIL ovf_slots: got %h expected %h", slots, e);
    end
    n_checks++;
    if (overflow !== m_ovf || overflow[2] !== 1'b1) begin
      n_fail++; $display("FAIL ovf_flags: got %b expected %b", overflow, m_ovf);
    end
  endtask

  task automatic test_simultaneous();
    int     acks;
    int     sacks;
    int     cacks;
    slots_t e;
    clr(acks);
    for (int p = 0; p < 7; p++) pulse(1, 2, 2);
    sb.push_back(m_cnt);
    repeat (S + 2) @(negedge clk);
    snapshot_req = 1'b1;
    clear_req    = 1'b1;
    m_cnt = '0;
    m_ovf = '0;
    sacks = 0;
    cacks = 0;
    repeat (12) begin
      @(negedge clk);
      if (snapshot_ack) sacks++;
      if (clear_ack)    cacks++;
    end
    snapshot_req = 1'b0;
    clear_req    = 1'b0;
    repeat (2) @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (slots !== e || slots[1] !== 32'd7) begin
      n_fail++; $display("FAIL simul_slots: got %h expected %h", slots, e);
    end
    n_checks++;
    if (sacks !== 1 || cacks !== 1) begin
      n_fail++; $display("FAIL simul_acks: got snap=%0d clear=%0d expected 1/1", sacks, cacks);
    end
    n_checks++;
    if (overflow !== m_ovf) begin
      n_fail++; $display("FAIL simul_overflow: got %b expected %b", overflow, m_ovf);
    end
    snap(acks);
    e = sb.pop_front();
    n_checks++;
    if (slots !== e) begin
      n_fail++; $display("FAIL simul_resnap_slots: got %h expected %h", slots, e);
    end
    n_checks++;
    if (acks !== 1) begin
      n_fail++; $display("FAIL simul_resnap_acks: got %0d expected 1", acks);
    end
  endtask

  task automatic test_clear_edge();
    int     acks;
    int     cacks;
    slots_t e;
    for (int p = 0; p < 3; p++) pulse(3, 2, 2);
    repeat (S + 2) @(negedge clk);
    // Time the rising edge so it is detected on the clear accept cycle.
    event_in[3] = 1'b1;
    repeat (S) @(negedge clk);
    clear_req = 1'b1;
    m_cnt    = '0;
    m_ovf    = '0;
    m_cnt[3] = 32'd1;
    cacks = 0;
    repeat (8) begin
      @(negedge clk);
      if (clear_ack) cacks++;
    end
    clear_req   = 1'b0;
    event_in[3] = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (cacks !== 1) begin
      n_fail++; $display("FAIL clredge_acks: got %0d expected 1", cacks);
    end
    snap(acks);
    e = sb.pop_front();
    n_checks++;
    if (slots !== e) begin
      n_fail++; $display("FAIL clredge_slots: got %h expected %h", slots, e);
    end
    n_checks++;
    if (acks !== 1) begin
      n_fail++; $display("FAIL clredge_snap_acks: got %0d expected 1", acks);
    end
  endtask

  task automatic test_reset_mid();
    int     acks;
    slots_t e;
    clr(acks);
    for (int p = 0; p < 3; p++) pulse(0, 2, 2);
    repeat (S + 2) @(negedge clk);
    snapshot_req = 1'b1;
    acks = 0;
    for (int c = 0; c < 20 && acks == 0; c++) begin
      @(negedge clk);
      if (snapshot_ack) acks++;
    end
    n_checks++;
    if (acks !== 1) begin
      n_fail++; $display("FAIL rstmid_reach_ack: got %0d expected 1", acks);
    end
    rst = 1'b0;
    m_cnt = '0;
    m_ovf = '0;
    #1;
    n_checks++;
    if (snapshot_ack !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_ack_abort: got %b expected 0", snapshot_ack);
    end
    n_checks++;
    if (slots !== '0) begin
      n_fail++; $display("FAIL rstmid_slots_async: got %h expected 0", slots);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb.push_back(m_cnt);
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      if (snapshot_ack) acks++;
    end
    snapshot_req = 1'b0;
    repeat (2) @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (acks !== 1) begin
      n_fail++; $display("FAIL rstmid_reservice_acks: got %0d expected 1", acks);
    end
    n_checks++;
    if (slots !== e) begin
      n_fail++; $display("FAIL rstmid_reservice_slots: got %h expected %h", slots, e);
    end
  endtask

  task automatic test_toggle();
    int     acks;
    slots_t e;
    clr(acks);
    for (int i = 0; i < 1000; i++) begin
      if (i % 2 == 0) begin
        event_in = '1;
        for (int k = 0; k < N; k++) model_edge(k);
      end else begin
        event_in = '0;
      end
      @(negedge clk);
    end
    event_in = '0;
    snap(acks);
    e = sb.pop_front();
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (slots[k] !== e[k] || slots[k] !== 32'd500) begin
        n_fail++; $display("FAIL toggle_slot%0d: got %0d expected %0d", k, slots[k], e[k]);
      end
    end
    n_checks++;
    if (acks !== 1) begin
      n_fail++; $display("FAIL toggle_acks: got %0d expected 1", acks);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_simultaneous();
    test_clear_edge();
    test_reset_mid();
    test_toggle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
